// File: rtl/alu_instr_sequencer.sv
// Hardwired control-step sequencer: fetches an instruction via PC/MAR/MDR/IR and steps
// the register-transfer datapath through register-format ALU, mul/div, nop and halt.
module alu_instr_sequencer #(
   parameter logic [4:0]  INC_CODE = 5'b11111,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [31:0]      ir_in,
   output logic             PCout,
   output logic             MARin,
   output logic             IncPC,
   output logic             Zin,
   output logic             Read,
   output logic             MDRin,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             PCin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             HIin,
   output logic             LOin,
   output logic [15:0]      R_in,
   output logic [15:0]      R_out,
   output logic [4:0]       ALU_Control,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             illegal_q, illegal_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_muldiv, retire;
   logic       ir_unused;

   assign opcode    = ir_in[31:27];
   assign ra        = ir_in[26:23];
   assign rb        = ir_in[22:19];
   assign rc        = ir_in[18:15];
   assign ir_unused = ^ir_in[14:0];

   assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
   assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q       <= S_IDLE;
         instr_count_q <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
         illegal_q     <= illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      instr_count_d = instr_count_q;
      illegal_d     = illegal_q;
      retire        = 1'b0;
      PCout         = 1'b0;
      MARin         = 1'b0;
      IncPC         = 1'b0;
      Zin           = 1'b0;
      Read          = 1'b0;
      MDRin         = 1'b0;
      Zlowout       = 1'b0;
      Zhighout      = 1'b0;
      PCin          = 1'b0;
      MDRout        = 1'b0;
      IRin          = 1'b0;
      Yin           = 1'b0;
      HIin          = 1'b0;
      LOin          = 1'b0;
      R_in          = '0;
      R_out         = '0;
      ALU_Control   = '0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_T0;
         end
         S_T0: begin
            PCout       = 1'b1;
            MARin       = 1'b1;
            IncPC       = 1'b1;
            Zin         = 1'b1;
            ALU_Control = INC_CODE;
            state_d     = S_T1;
         end
         // PC reload from an unchanged Z is harmless, so the wait loop keeps every strobe up.
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) state_d = S_T2;
         end
         S_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            if (is_alu) begin
               R_out[rb] = 1'b1;
               Yin       = 1'b1;
               state_d   = S_T4;
            end else if (is_muldiv) begin
               R_out[ra] = 1'b1;
               Yin       = 1'b1;
               state_d   = S_T4;
            end else if (opcode == OP_NOP) begin
               retire = 1'b1;
            end else if (opcode == OP_HALT) begin
               state_d = S_HALT;
            end else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_T4: begin
            Zin         = 1'b1;
            ALU_Control = opcode;
            if (is_muldiv) R_out[rb] = 1'b1;
            else           R_out[rc] = 1'b1;
            state_d     = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_muldiv) begin
               LOin    = 1'b1;
               state_d = S_T6;
            end else begin
               R_in[ra] = 1'b1;
               retire   = 1'b1;
            end
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            retire   = 1'b1;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // run is only consulted at retire, so dropping it mid-instruction never aborts.
      if (retire) begin
         instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         state_d       = run ? S_T0 : S_IDLE;
      end
   end

   assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
   assign done        = (state_q == S_HALT);
   assign illegal     = illegal_q;
   assign instr_count = instr_count_q;

endmodule
